// File: rtl/latch_sr_pkg.sv
// latch_sr_pkg
//   Shared definitions for the gated SR latch monitor.
//   - state_e : monitor FSM states; the numeric encoding is visible on o_state
//   - SETTLE_CYCLES_DEFAULT : default settle delay in clocks
package latch_sr_pkg;

   typedef enum logic [1:0] {
      ST_UNKNOWN = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CHECK   = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_e;

   localparam int SETTLE_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for one asynchronous bit.
//   Ports:
//     clock   in  sampling clock, rising edge
//     reset_n in  asynchronous active-low reset; both flops clear to 0
//     d       in  asynchronous input
//     q       out synchronized copy of d, two clocks of latency
module sync_2ff (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/latch_sr_monitor.sv
// latch_sr_monitor
//   Checker placed beside a gated SR latch. It synchronizes the latch inputs
//   and outputs, runs a reference model of the latch, and flags output
//   mismatches and the illegal S=R=1 drive while enabled.
//   Ports:
//     clock, reset_n           sampling clock, async active-low reset
//     mon_enable/set/reset     latch inputs (asynchronous)
//     mon_q, mon_q_            latch outputs (asynchronous)
//     o_expected_q, o_known    model state; o_expected_q meaningful when o_known=1
//     o_state                  FSM state (0 UNKNOWN, 1 SETTLE, 2 CHECK, 3 ILLEGAL)
//     o_mismatch, o_illegal    one-clock event pulses
//     o_error_count            saturating count of both pulse kinds
//   Optional build macro LATCH_SR_MONITOR_STICKY_EN adds o_error_sticky,
//   set by any error pulse and cleared only by reset_n.
//   Handshake: none; every output is a registered level or one-clock pulse.
module latch_sr_monitor
   import latch_sr_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 mon_enable,
   input  logic                 mon_set,
   input  logic                 mon_reset,
   input  logic                 mon_q,
   input  logic                 mon_q_,
   output logic                 o_expected_q,
   output logic                 o_known,
   output logic [1:0]           o_state,
   output logic                 o_mismatch,
   output logic                 o_illegal,
   output logic [ERR_CNT_W-1:0] o_error_count
`ifdef LATCH_SR_MONITOR_STICKY_EN
   ,
   output logic                 o_error_sticky
`endif
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   logic en_s, s_s, r_s, q_s, qn_s;

   sync_2ff u_sync_en (.clock(clock), .reset_n(reset_n), .d(mon_enable), .q(en_s));
   sync_2ff u_sync_s  (.clock(clock), .reset_n(reset_n), .d(mon_set),    .q(s_s));
   sync_2ff u_sync_r  (.clock(clock), .reset_n(reset_n), .d(mon_reset),  .q(r_s));
   sync_2ff u_sync_q  (.clock(clock), .reset_n(reset_n), .d(mon_q),      .q(q_s));
   sync_2ff u_sync_qn (.clock(clock), .reset_n(reset_n), .d(mon_q_),     .q(qn_s));

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   exp_q, exp_d;
   logic                   known_q, known_d;
   logic [2:0]             in_prev_q, in_prev_d;
   logic                   mm_prev_q, mm_prev_d;
   logic                   mismatch_q, mismatch_d;
   logic                   illegal_q, illegal_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic [2:0] in_now;
   logic       in_chg;
   logic       drive_in;
   logic       illegal_in;
   logic       mm;

   assign in_now     = {en_s, s_s, r_s};
   assign in_chg     = (in_now != in_prev_q);
   assign drive_in   = en_s & (s_s ^ r_s);
   assign illegal_in = en_s & s_s & r_s;
   // Q must match the model and Q' must be the complement of Q.
   assign mm         = (q_s != exp_q) | (qn_s != ~q_s);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      exp_d      = exp_q;
      known_d    = known_q;
      in_prev_d  = in_now;
      mm_prev_d  = 1'b0;
      mismatch_d = 1'b0;
      illegal_d  = 1'b0;

      // Reference model of the latch.
      if (en_s & s_s & ~r_s) begin
         exp_d   = 1'b1;
         known_d = 1'b1;
      end else if (en_s & ~s_s & r_s) begin
         exp_d   = 1'b0;
         known_d = 1'b1;
      end else if (illegal_in) begin
         known_d = 1'b0;
      end

      if (illegal_in) begin
         state_d   = ST_ILLEGAL;
         cnt_d     = 4'd0;
         illegal_d = (state_q != ST_ILLEGAL);
      end else begin
         case (state_q)
            ST_UNKNOWN: begin
               if (drive_in) begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end
            end
            ST_SETTLE: begin
               if (in_chg) begin
                  cnt_d = SETTLE_LOAD;
               end else if (cnt_q <= 4'd1) begin
                  // Counter hits zero on the same edge the FSM enters CHECK.
                  state_d = ST_CHECK;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            ST_CHECK: begin
               if (in_chg) begin
                  // An input change wins over a coincident mismatch edge.
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end else begin
                  // mm_prev is 0 outside CHECK, so a mismatch already present
                  // on entry counts as a rising edge.
                  mm_prev_d  = mm;
                  mismatch_d = mm & ~mm_prev_q;
               end
            end
            ST_ILLEGAL: begin
               if (drive_in) begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end else if (!en_s) begin
                  state_d = ST_UNKNOWN;
               end
            end
            default: begin
               state_d = ST_UNKNOWN;
            end
         endcase
      end

      err_cnt_d = err_cnt_q;
      if ((mismatch_d | illegal_d) && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_UNKNOWN;
         cnt_q      <= 4'd0;
         exp_q      <= 1'b0;
         known_q    <= 1'b0;
         in_prev_q  <= 3'b000;
         mm_prev_q  <= 1'b0;
         mismatch_q <= 1'b0;
         illegal_q  <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         exp_q      <= exp_d;
         known_q    <= known_d;
         in_prev_q  <= in_prev_d;
         mm_prev_q  <= mm_prev_d;
         mismatch_q <= mismatch_d;
         illegal_q  <= illegal_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

`ifdef LATCH_SR_MONITOR_STICKY_EN
   logic sticky_q, sticky_d;

   always_comb begin
      sticky_d = sticky_q | mismatch_d | illegal_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign o_error_sticky = sticky_q;
`endif

   assign o_expected_q  = exp_q;
   assign o_known       = known_q;
   assign o_state       = state_q;
   assign o_mismatch    = mismatch_q;
   assign o_illegal     = illegal_q;
   assign o_error_count = err_cnt_q;

endmodule
